uart_rx_pixel_unpacker: RTL and testbench

//  Receive path of the PC<->FPGA UART link: deserialises 8N1 bytes on rx, buffers them in a small

---
 rtl/uart_rx_pixel_unpacker_if.sv | 11 +
 rtl/uart_rx_pixel_unpacker.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_pixel_unpacker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pixel_unpacker_if.sv
// Pixel stream interface of the UART receive path: valid/ready handshake plus frame markers.
interface uart_rx_pixel_unpacker_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic       frame_start;
  logic       frame_done;

  modport master (output pix_valid, pix_data, frame_start, frame_done, input pix_ready);
  modport slave  (input pix_valid, pix_data, frame_start, frame_done, output pix_ready);
endinterface

// File: rtl/uart_rx_pixel_unpacker.sv
// UART 8N1 receiver -> byte FIFO -> 1-bit-per-pixel unpacker with frame byte counting.
// Optional feature macro: UART_RX_TIMEOUT_EN (idle timeout abandons a partial frame).
module uart_rx_pixel_unpacker #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_BYTES  = 5280,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  uart_rx_pixel_unpacker_if.master        pix,
  output logic                            frame_err,
  output logic                            overrun
);
  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = $clog2(FRAME_BYTES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {UP_LOAD, UP_EMIT} up_state_t;

  logic             rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  rx_state_t        rx_state_q, rx_state_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_shreg_q, rx_shreg_d;
  logic             push_q, push_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             fifo_full, fifo_empty, push_ok, pop;
  up_state_t        up_state_q, up_state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout_hit;

  assign tick       = (div_cnt_q == DIV_W'(DIV - 1));
  assign div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = (up_state_q == UP_LOAD) && !fifo_empty;
  // A full FIFO still accepts a byte when the unpacker frees a slot in the same cycle.
  assign push_ok    = push_q && (!fifo_full || pop);
  assign overrun_d  = push_q && fifo_full && !pop;
  assign wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
  assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
  assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

  always_comb begin
    rx_state_d  = rx_state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shreg_d  = rx_shreg_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_sync_q) begin
        rx_state_d = RX_START;
        tick_cnt_d = '0;
      end
      RX_START: if (tick) begin
        if (tick_cnt_q == 4'd7) begin
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end else tick_cnt_d = tick_cnt_q + 4'd1;
      end
      RX_DATA: if (tick) begin
        if (tick_cnt_q == 4'd15) begin
          rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
          tick_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else tick_cnt_d = tick_cnt_q + 4'd1;
      end
      RX_STOP: if (tick) begin
        if (tick_cnt_q == 4'd15) begin
          push_d      = rx_sync_q;
          frame_err_d = !rx_sync_q;
          rx_state_d  = RX_IDLE;
        end else tick_cnt_d = tick_cnt_q + 4'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int IDLE_LIMIT = TIMEOUT_BITS * 16;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              all_idle;

  assign all_idle    = (rx_state_q == RX_IDLE) && fifo_empty && (up_state_q == UP_LOAD);
  assign timeout_hit = all_idle && tick && (idle_cnt_q == IDLE_W'(IDLE_LIMIT - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (rx_state_q != RX_IDLE)  idle_cnt_d = '0;
    else if (timeout_hit)       idle_cnt_d = '0;
    else if (all_idle && tick)  idle_cnt_d = idle_cnt_q + IDLE_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    up_state_d   = up_state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    byte_cnt_d   = byte_cnt_q;
    frame_done_d = 1'b0;
    case (up_state_q)
      UP_LOAD: if (pop) begin
        shreg_d    = fifo_mem_q[rd_ptr_q];
        bit_idx_d  = 3'd7;
        byte_cnt_d = byte_cnt_q + BC_W'(1);
        up_state_d = UP_EMIT;
      end
      UP_EMIT: if (pix.pix_ready) begin
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_idx_d = bit_idx_q - 3'd1;
        if (bit_idx_q == 3'd0) begin
          up_state_d = UP_LOAD;
          // byte_cnt counts popped bytes, so FRAME_BYTES means the frame's last byte just finished.
          if (byte_cnt_q == BC_W'(FRAME_BYTES)) begin
            byte_cnt_d   = '0;
            frame_done_d = 1'b1;
          end
        end
      end
      default: up_state_d = UP_LOAD;
    endcase
    if (timeout_hit) byte_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      div_cnt_q    <= '0;
      rx_state_q   <= RX_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      up_state_q   <= UP_LOAD;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      div_cnt_q    <= div_cnt_d;
      rx_state_q   <= rx_state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      push_q       <= push_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      up_state_q   <= up_state_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Payload registers carry no reset; control state alone decides when they are meaningful.
  always_ff @(posedge clk) begin
    rx_shreg_q <= rx_shreg_d;
    shreg_q    <= shreg_d;
    if (push_ok) fifo_mem_q[wr_ptr_q] <= rx_shreg_q;
  end

  assign pix.pix_valid   = (up_state_q == UP_EMIT);
  assign pix.pix_data    = (pix.pix_valid && shreg_q[7]) ? 8'hFF : 8'h00;
  assign pix.frame_start = pix.pix_valid && (byte_cnt_q == BC_W'(1));
  assign pix.frame_done  = frame_done_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
endmodule

// File: tb/tb_uart_rx_pixel_unpacker.sv
// Self-checking bench: table-driven single-byte vectors plus hand sequences, pixel scoreboard.
module tb_uart_rx_pixel_unpacker;
  localparam int BIT = 32;  // clocks per bit: 3.2 MHz / (100 kBd * 16) = 2 clk per tick
  localparam int FB  = 4;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic frame_err, overrun;
  always #5 clk = ~clk;

  uart_rx_pixel_unpacker_if pif();

  uart_rx_pixel_unpacker #(
    .CLK_FREQ(3_200_000), .BAUD(100_000), .FIFO_DEPTH(16),
    .FRAME_BYTES(FB), .TIMEOUT_BITS(64)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .pix(pif.master),
    .frame_err(frame_err), .overrun(overrun)
  );

  typedef struct {logic [7:0] data; logic fs; logic last;} pix_t;
  typedef struct {logic [7:0] data; logic stop; logic [63:0] pix; int npix; int nerr;} vec_t;

  pix_t sb[$];
  int   checks = 0, errors = 0;
  int   mdl_byte = 0, err_cnt = 0, ovr_cnt = 0, done_cnt = 0;
  logic exp_done = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] expand(input logic [7:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = b[7-i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  task automatic push_exp(input logic [63:0] pats);
    pix_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = pats[63-8*i -: 8];
      e.fs   = (mdl_byte == 0);
      e.last = (i == 7) && (mdl_byte == FB - 1);
      sb.push_back(e);
    end
    mdl_byte = (mdl_byte + 1) % FB;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT);
    end
    rx = stop;
    if (stop) wait_clk(BIT);
    else begin
      wait_clk(BIT * 3 / 4);
      rx = 1'b1;
      wait_clk(BIT / 4);
    end
    rx = 1'b1;
    wait_clk(BIT);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx = 1'b1;
    pif.pix_ready = 1'b1;
    wait_clk(3);
    check("reset_outputs",
          {pif.pix_valid, pif.pix_data, pif.frame_start, pif.frame_done, frame_err, overrun}, '0);
    sb.delete();
    mdl_byte = 0;
    err_cnt = 0;
    ovr_cnt = 0;
    done_cnt = 0;
    reset = 1'b1;
    wait_clk(2);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      wait_clk(1);
      n++;
    end
    wait_clk(4);
    check("drain_left", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (!reset) begin
      prev_stall = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done || pif.frame_done) check("frame_done", pif.frame_done, exp_done);
      if (pif.frame_done) done_cnt++;
      exp_done = 1'b0;
      if (prev_stall) check("stall_hold", {pif.pix_valid, pif.pix_data}, {1'b1, prev_data});
      if (frame_err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (pif.pix_valid && pif.pix_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %0h expected none", pif.pix_data);
        end else begin
          e = sb.pop_front();
          check("pix_data", pif.pix_data, e.data);
          check("frame_start", pif.frame_start, e.fs);
          exp_done = e.last;
        end
      end
      prev_stall = pif.pix_valid && !pif.pix_ready;
      prev_data = pif.pix_data;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[5];
    logic [7:0] b;
    reset = 1'b0;
    rx = 1'b1;
    pif.pix_ready = 1'b1;
    tbl[0] = '{8'hA5, 1'b1, 64'hFF00FF0000FF00FF, 8, 0};
    tbl[1] = '{8'h3C, 1'b0, 64'h0,                0, 1};
    tbl[2] = '{8'h01, 1'b1, 64'h00000000000000FF, 8, 0};
    tbl[3] = '{8'h80, 1'b1, 64'hFF00000000000000, 8, 0};
    tbl[4] = '{8'h00, 1'b1, 64'h0000000000000000, 8, 0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      if (tbl[i].npix != 0) push_exp(tbl[i].pix);
      send_byte(tbl[i].data, tbl[i].stop);
      drain(200);
      check("tbl_frame_err", err_cnt, tbl[i].nerr);
      check("tbl_overrun", ovr_cnt, 0);
    end

    // Full frame of 4 x 0xFF: frame_start on first byte, single frame_done.
    do_reset();
    for (int i = 0; i < FB; i++) begin
      push_exp(64'hFFFFFFFFFFFFFFFF);
      send_byte(8'hFF, 1'b1);
    end
    drain(200);
    check("frame_done_count", done_cnt, 1);

    // Bad stop bit leaves the byte counter at 0.
    do_reset();
    send_byte(8'h3C, 1'b0);
    push_exp(expand(8'h80));
    send_byte(8'h80, 1'b1);
    drain(200);
    check("err_then_ok_err", err_cnt, 1);

    // Backpressure: 1 byte in the unpacker + 16 in the FIFO, the 18th overruns.
    do_reset();
    pif.pix_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      b = 8'(i * 29 + 3);
      if (i < 17) push_exp(expand(b));
      send_byte(b, 1'b1);
    end
    check("overrun_count", ovr_cnt, 1);
    pif.pix_ready = 1'b1;
    drain(1000);
    check("bp_frame_done_count", done_cnt, 4);

    // Short low glitch on idle line is rejected.
    do_reset();
    rx = 1'b0;
    wait_clk(10);
    rx = 1'b1;
    wait_clk(BIT * 2);
    check("glitch_err", err_cnt, 0);
    check("glitch_valid", pif.pix_valid, 0);

    // Reset in the middle of a byte after a partial frame.
    push_exp(expand(8'h3C));
    send_byte(8'h3C, 1'b1);
    drain(200);
    rx = 1'b0;
    wait_clk(BIT * 4);
    do_reset();
    wait_clk(BIT * 12);
    check("post_reset_valid", pif.pix_valid, 0);
    push_exp(expand(8'h80));
    send_byte(8'h80, 1'b1);
    drain(200);
    check("post_reset_err", err_cnt, 0);

`ifdef UART_RX_TIMEOUT_EN
    // Idle timeout abandons a partial frame: next byte is byte 0 again.
    do_reset();
    push_exp(expand(8'h11));
    send_byte(8'h11, 1'b1);
    push_exp(expand(8'h22));
    send_byte(8'h22, 1'b1);
    drain(200);
    wait_clk(64 * BIT + 200);
    mdl_byte = 0;
    push_exp(expand(8'h80));
    send_byte(8'h80, 1'b1);
    drain(200);
    check("timeout_no_done", done_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
